// File: rtl/up_counter_mod.sv
// Modulo-MODULUS up counter behind an enable prescaler, with synchronous clear/load,
// a combinational terminal count for cascading, a registered carry pulse and a sticky overflow.
module up_counter_mod #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH) || PRESCALE < 1 ||
      WIDTH < 1 || WIDTH > 32 || PRESCALE > 65536) begin : g_param_err
    $fatal(1, "up_counter_mod: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  logic [PW-1:0] presc;
  logic          step;
  logic          at_max;

  // With PRESCALE=1 the prescaler is pinned at 0 == PMAX, so step collapses to en.
  assign step   = en && (presc == PMAX);
  assign at_max = (counter == MAXV);
  // Exposed before the edge so a downstream stage can use it directly as its enable.
  assign tc     = step && at_max && !clear && !load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      presc     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      counter   <= '0;
      presc     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      // Out-of-range load values saturate so the counter never leaves 0..MODULUS-1.
      counter   <= (load_val > MAXV) ? MAXV : load_val;
      presc     <= '0;
      carry_out <= 1'b0;
    end else if (step) begin
      presc <= '0;
      if (at_max) begin
        counter   <= '0;
        carry_out <= 1'b1;
        overflow  <= 1'b1;
      end else begin
        counter   <= counter + WIDTH'(1);
        carry_out <= 1'b0;
      end
    end else if (en) begin
      presc     <= presc + PW'(1);
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
    end
  end

endmodule
